// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory port arbiter.
// Holds the response record, the slot state encoding and the alignment helper.
package imem_pkg;

  localparam int WORD_BYTES = 4;
  localparam int PORT_FETCH = 0;
  localparam int PORT_DBG   = 1;

  localparam logic [1:0] ALIGN_MASK = 2'(WORD_BYTES - 1);

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } rsp_t;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_st_e;

  function automatic logic misaligned(
    input logic [1:0] lsb
  );
    return (lsb & ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/imem_port_arbiter_if.sv
// Bundle of both requester channels plus the memory read port.
// The master side is the requesters and memory; the slave side is the arbiter.
interface imem_port_arbiter_if #(
  parameter int N = 7
);

  logic         req0_valid;
  logic [N-1:0] req0_addr;
  logic         req0_ready;
  logic         rsp0_valid;
  logic         rsp0_ready;
  logic [31:0]  rsp0_data;
  logic         rsp0_err;

  logic         req1_valid;
  logic [N-1:0] req1_addr;
  logic         req1_ready;
  logic         rsp1_valid;
  logic         rsp1_ready;
  logic [31:0]  rsp1_data;
  logic         rsp1_err;

  logic [N-1:0] mem_addr;
  logic [31:0]  mem_rd;

  modport master (
    output req0_valid,
    output req0_addr,
    output rsp0_ready,
    output req1_valid,
    output req1_addr,
    output rsp1_ready,
    output mem_rd,
    input  req0_ready,
    input  rsp0_valid,
    input  rsp0_data,
    input  rsp0_err,
    input  req1_ready,
    input  rsp1_valid,
    input  rsp1_data,
    input  rsp1_err,
    input  mem_addr
  );

  modport slave (
    input  req0_valid,
    input  req0_addr,
    input  rsp0_ready,
    input  req1_valid,
    input  req1_addr,
    input  rsp1_ready,
    input  mem_rd,
    output req0_ready,
    output rsp0_valid,
    output rsp0_data,
    output rsp0_err,
    output req1_ready,
    output rsp1_valid,
    output rsp1_data,
    output rsp1_err,
    output mem_addr
  );

endinterface

// File: rtl/imem_rsp_slot.sv
// One-entry valid/ready response register for one arbiter port.
// A load while full overwrites in place, so drain-and-refill has no bubble.
module imem_rsp_slot
  import imem_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic [31:0] load_data_i,
  input  logic        load_err_i,
  input  logic        rsp_ready_i,
  output logic        rsp_valid_o,
  output rsp_t        rsp_o
);

  slot_st_e st_q;
  rsp_t     rsp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q  <= SLOT_EMPTY;
      rsp_q <= '0;
    end else begin
      unique case (st_q)
        SLOT_EMPTY: begin
          if (load_i) begin
            st_q  <= SLOT_FULL;
            rsp_q <= '{data: load_data_i, err: load_err_i};
          end
        end
        SLOT_FULL: begin
          if (load_i) begin
            rsp_q <= '{data: load_data_i, err: load_err_i};
          end else if (rsp_ready_i) begin
            st_q <= SLOT_EMPTY;
          end
        end
        default: st_q <= SLOT_EMPTY;
      endcase
    end
  end

  assign rsp_valid_o = (st_q == SLOT_FULL);
  assign rsp_o       = rsp_q;

endmodule

// File: rtl/imem_port_arbiter.sv
// Two-port arbiter sharing one combinational imem read port, one-cycle latency.
// Define IMEM_ARB_RR_EN for round-robin ties; otherwise fetch wins every tie.
module imem_port_arbiter
  import imem_pkg::*;
#(
  parameter int N = 7
) (
  input logic clk,
  input logic rst_n,
  imem_port_arbiter_if.slave bus
);

  logic [1:0]   valid;
  logic [1:0]   rdy;
  logic [1:0]   full;
  logic [1:0]   elig;
  logic [1:0]   grant;
  logic         tie_to_dbg;
  logic [N-1:0] addr0;
  logic [N-1:0] addr1;
  logic [N-1:0] mem_addr;
  logic         ld_err;
  rsp_t         rsp0;
  rsp_t         rsp1;

  assign valid = {bus.req1_valid, bus.req0_valid};
  assign rdy   = {bus.rsp1_ready, bus.rsp0_ready};
  assign addr0 = bus.req0_addr;
  assign addr1 = bus.req1_addr;

  // A full slot is eligible only if it drains this same cycle.
  assign elig = valid & (~full | rdy);

`ifdef IMEM_ARB_RR_EN
  logic last_grant_q;
  logic last_grant_d;

  assign tie_to_dbg = (last_grant_q == 1'(PORT_FETCH));

  always_comb begin
    last_grant_d = last_grant_q;
    if (grant[PORT_DBG]) begin
      last_grant_d = 1'(PORT_DBG);
    end else if (grant[PORT_FETCH]) begin
      last_grant_d = 1'(PORT_FETCH);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'(PORT_DBG);
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`else
  assign tie_to_dbg = 1'b0;
`endif

  always_comb begin
    grant = '0;
    if (rst_n) begin
      unique case (1'b1)
        (elig == 2'b11): begin
          if (tie_to_dbg) grant[PORT_DBG] = 1'b1;
          else grant[PORT_FETCH] = 1'b1;
        end
        (elig == 2'b01): grant[PORT_FETCH] = 1'b1;
        (elig == 2'b10): grant[PORT_DBG] = 1'b1;
        default: grant = '0;
      endcase
    end
  end

  assign mem_addr = grant[PORT_DBG] ? addr1 : addr0;
  assign ld_err   = misaligned(mem_addr[1:0]);

  imem_rsp_slot u_slot0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (grant[PORT_FETCH]),
    .load_data_i(bus.mem_rd),
    .load_err_i (ld_err),
    .rsp_ready_i(bus.rsp0_ready),
    .rsp_valid_o(full[PORT_FETCH]),
    .rsp_o      (rsp0)
  );

  imem_rsp_slot u_slot1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (grant[PORT_DBG]),
    .load_data_i(bus.mem_rd),
    .load_err_i (ld_err),
    .rsp_ready_i(bus.rsp1_ready),
    .rsp_valid_o(full[PORT_DBG]),
    .rsp_o      (rsp1)
  );

  assign bus.mem_addr   = mem_addr;
  assign bus.req0_ready = grant[PORT_FETCH];
  assign bus.req1_ready = grant[PORT_DBG];
  assign bus.rsp0_valid = full[PORT_FETCH];
  assign bus.rsp0_data  = rsp0.data;
  assign bus.rsp0_err   = rsp0.err;
  assign bus.rsp1_valid = full[PORT_DBG];
  assign bus.rsp1_data  = rsp1.data;
  assign bus.rsp1_err   = rsp1.err;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a
// transaction-level model of two response slots and a shared memory.
module tb_imem_port_arbiter;

  localparam int N = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imem_port_arbiter_if #(.N(N)) bus ();

  imem_port_arbiter #(.N(N)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [7:0] mem [128];

  always_comb begin
    bus.mem_rd = {mem[bus.mem_addr],
                  mem[bus.mem_addr + 7'd1],
                  mem[bus.mem_addr + 7'd2],
                  mem[bus.mem_addr + 7'd3]};
  end

  int checks = 0;
  int errors = 0;

  bit          m_full [2];
  logic [31:0] m_data [2];
  bit          m_err  [2];
  int          m_last = 1;
  bit          d_rdy0, d_rdy1;

  function automatic logic [31:0] word(input int a);
    return {mem[a % 128], mem[(a + 1) % 128],
            mem[(a + 2) % 128], mem[(a + 3) % 128]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic step(input bit v0, input int a0, input bit r0,
                      input bit v1, input int a1, input bit r1);
    bit e [2];
    bit g [2];
    bit v [2];
    bit r [2];
    int a [2];
    @(negedge clk);
    bus.req0_valid = v0;
    bus.req0_addr  = 7'(a0);
    bus.rsp0_ready = r0;
    bus.req1_valid = v1;
    bus.req1_addr  = 7'(a1);
    bus.rsp1_ready = r1;
    v[0] = v0; v[1] = v1;
    r[0] = r0; r[1] = r1;
    a[0] = a0 % 128; a[1] = a1 % 128;
    #1;
    for (int p = 0; p < 2; p++) e[p] = v[p] && (!m_full[p] || r[p]);
    g[0] = 0; g[1] = 0;
    if (e[0] && e[1]) begin
`ifdef IMEM_ARB_RR_EN
      g[1 - m_last] = 1;
`else
      g[0] = 1;
`endif
    end else if (e[0]) g[0] = 1;
    else if (e[1]) g[1] = 1;
    d_rdy0 = bus.req0_ready;
    d_rdy1 = bus.req1_ready;
    chk("req0_ready", 32'(bus.req0_ready), 32'(g[0]));
    chk("req1_ready", 32'(bus.req1_ready), 32'(g[1]));
    chk("mem_addr", 32'(bus.mem_addr), 32'(g[1] ? a[1] : a[0]));
    chk("rsp0_valid", 32'(bus.rsp0_valid), 32'(m_full[0]));
    chk("rsp1_valid", 32'(bus.rsp1_valid), 32'(m_full[1]));
    if (m_full[0]) begin
      chk("rsp0_data", bus.rsp0_data, m_data[0]);
      chk("rsp0_err", 32'(bus.rsp0_err), 32'(m_err[0]));
    end
    if (m_full[1]) begin
      chk("rsp1_data", bus.rsp1_data, m_data[1]);
      chk("rsp1_err", 32'(bus.rsp1_err), 32'(m_err[1]));
    end
    @(posedge clk);
    for (int p = 0; p < 2; p++) begin
      if (g[p]) begin
        m_full[p] = 1;
        m_data[p] = word(a[p]);
        m_err[p]  = (a[p] % 4) != 0;
        m_last    = p;
      end else if (m_full[p] && r[p]) begin
        m_full[p] = 0;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    m_full[0] = 0; m_full[1] = 0;
    m_last = 1;
    #1;
    chk("rst rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
    chk("rst rsp0_data", bus.rsp0_data, 32'd0);
    chk("rst rsp1_valid", 32'(bus.rsp1_valid), 32'd0);
    chk("rst rsp1_err", 32'(bus.rsp1_err), 32'd0);
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    #1;
    chk("rst req0_ready", 32'(bus.req0_ready), 32'd0);
    chk("rst req1_ready", 32'(bus.req1_ready), 32'd0);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    bit exp_tie [4];
    bus.req0_valid = 0; bus.req0_addr = '0; bus.rsp0_ready = 0;
    bus.req1_valid = 0; bus.req1_addr = '0; bus.rsp1_ready = 0;
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    do_reset();

    // single aligned fetch
    mem[4] = 8'h13; mem[5] = 8'h05; mem[6] = 8'h10; mem[7] = 8'h00;
    step(1, 'h04, 0, 0, 0, 0);
    #2;
    chk("fetch valid", 32'(bus.rsp0_valid), 32'd1);
    chk("fetch data", bus.rsp0_data, 32'h13051000);
    chk("fetch err", 32'(bus.rsp0_err), 32'd0);
    step(0, 0, 1, 0, 0, 1);

    // misaligned debug read
    mem[1] = 8'hAA; mem[2] = 8'hBB; mem[3] = 8'hCC; mem[4] = 8'hDD;
    step(0, 0, 1, 1, 'h01, 0);
    #2;
    chk("dbg data", bus.rsp1_data, 32'hAABBCCDD);
    chk("dbg err", 32'(bus.rsp1_err), 32'd1);
    step(0, 0, 1, 0, 0, 1);

    // backpressure then drain-and-refill
    for (int i = 0; i < 8; i++) mem[8 + i] = 8'(i + 1);
    step(1, 'h08, 0, 0, 0, 0);
    step(1, 'h0C, 0, 0, 0, 0);
    chk("bp req0_ready", 32'(d_rdy0), 32'd0);
    #2;
    chk("bp held data", bus.rsp0_data, 32'h01020304);
    step(1, 'h0C, 1, 0, 0, 0);
    chk("refill req0_ready", 32'(d_rdy0), 32'd1);
    #2;
    chk("refill valid", 32'(bus.rsp0_valid), 32'd1);
    chk("refill data", bus.rsp0_data, 32'h05060708);
    step(0, 0, 1, 0, 0, 1);

    // end-of-memory wrap
    mem[124] = 8'h11; mem[125] = 8'h22; mem[126] = 8'h33; mem[127] = 8'h44;
    mem[0] = 8'h55; mem[1] = 8'h66;
    step(1, 'h7C, 0, 0, 0, 0);
    #2;
    chk("wrap0 data", bus.rsp0_data, 32'h11223344);
    chk("wrap0 err", 32'(bus.rsp0_err), 32'd0);
    step(0, 0, 1, 1, 'h7E, 0);
    #2;
    chk("wrap1 data", bus.rsp1_data, 32'h33445566);
    chk("wrap1 err", 32'(bus.rsp1_err), 32'd1);
    step(0, 0, 1, 0, 0, 1);

    // reset with slot 0 full, then ties
    step(1, 'h20, 0, 0, 0, 0);
    do_reset();
`ifdef IMEM_ARB_RR_EN
    exp_tie = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_tie = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    for (int i = 0; i < 4; i++) begin
      step(1, 4 * i, 1, 1, 4 * i + 64, 1);
      chk("tie req0_ready", 32'(d_rdy0), 32'(exp_tie[i]));
      chk("tie req1_ready", 32'(d_rdy1), 32'(!exp_tie[i]));
    end
    step(0, 0, 1, 0, 0, 1);

    // random traffic
    for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 1500; i++) begin
      if (i % 300 == 299) do_reset();
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, 127)),
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 1) != 0, int'($urandom_range(0, 127)),
           $urandom_range(0, 2) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
